// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared types and helpers for the line scan sequencer.
//   state_t     : sequencer state (IDLE, RUN, SWEEP)
//   line_sel_t  : result of a line search, {found, addr}
//   next_line() : first enabled line strictly after addr in direction dir,
//                 wrapping modulo NUM_LINES. Starting from addr itself, the
//                 eighth candidate is addr again, so a lone enabled line
//                 finds itself.
// -----------------------------------------------------------------------------
package scan_pkg;

  localparam int ADDR_W    = 3;
  localparam int NUM_LINES = 8;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SWEEP = 2'd2
  } state_t;

  typedef struct packed {
    logic              found;
    logic [ADDR_W-1:0] addr;
  } line_sel_t;

  function automatic line_sel_t next_line(
    input logic [ADDR_W-1:0]    addr,
    input logic                 dir,
    input logic [NUM_LINES-1:0] mask
  );
    line_sel_t         res;
    logic [ADDR_W-1:0] cand;
    res.found = 1'b0;
    res.addr  = addr;
    // Walk from the farthest candidate to the nearest so the nearest
    // enabled line is the one left in res.
    for (int i = NUM_LINES; i >= 1; i--) begin
      cand = (dir == DIR_UP) ? (addr + ADDR_W'(i)) : (addr - ADDR_W'(i));
      if (mask[cand]) begin
        res.found = 1'b1;
        res.addr  = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
// Dwell prescaler. Counts 0..div and raises tick while count == div, then
// wraps to 0. clr forces the count back to 0 so a freshly loaded line gets
// its full dwell.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear of the count
//   div   : dwell divisor, dwell = div+1 cycles
//   tick  : dwell period complete (combinational from the count)
// -----------------------------------------------------------------------------
module scan_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // Compared against the live div, so a new divisor applies at the next compare.
  assign tick = (cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/line_scan_sequencer.sv
// -----------------------------------------------------------------------------
// line_scan_sequencer
// Drives the A,B,C select of a 3-to-8 line decoder, stepping through the
// enabled lines at a programmable dwell. Continuous scan (run level) or a
// single sweep (start pulse, done pulse at the end), up or down, with a
// per-line enable mask.
//   clk, rst_n : clock and asynchronous active-low reset
//   run        : continuous scan while high
//   start      : begin one sweep (sampled only in IDLE)
//   dir        : 0 ascending, 1 descending
//   mask       : line enables, bit i enables line i
//   div        : dwell = div+1 cycles per line
//   A,B,C      : select, A is the MSB
//   valid      : select is live
//   step       : pulse in the cycle the select takes a new value
//   busy       : RUN or SWEEP
//   done       : pulse at the end of a sweep
// Build option SCAN_BLANK_EN: each address change is preceded by one cycle
// with valid low; the new address then appears with valid and step, and its
// dwell starts after the blank.
// -----------------------------------------------------------------------------
module line_scan_sequencer
  import scan_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             start,
  input  logic             dir,
  input  logic [7:0]       mask,
  input  logic [DIV_W-1:0] div,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             valid,
  output logic             step,
  output logic             busy,
  output logic             done
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              valid_n, step_n, done_n;
  logic              tick, clr, blank, adv;
  line_sel_t         first_sel, adv_sel;
  logic              in_range;

  // first(dir) is a search that starts just past the opposite end.
  assign first_sel = next_line((dir == DIR_UP) ? ADDR_W'(NUM_LINES - 1) : '0, dir, mask);
  assign adv_sel   = next_line(addr, dir, mask);
  // A sweep may only move toward its end line, never wrap.
  assign in_range  = (dir == DIR_UP) ? (adv_sel.addr > addr) : (adv_sel.addr < addr);

  assign clr = (state == IDLE) || blank;

  scan_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .div   (div),
    .tick  (tick)
  );

`ifdef SCAN_BLANK_EN
  logic              blank_n;
  logic [ADDR_W-1:0] pend, pend_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank <= 1'b0;
      pend  <= '0;
    end else begin
      blank <= blank_n;
      pend  <= pend_n;
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    state_n = state;
    addr_n  = addr;
    valid_n = valid;
    step_n  = 1'b0;
    done_n  = 1'b0;
    adv     = 1'b0;
`ifdef SCAN_BLANK_EN
    blank_n = 1'b0;
    pend_n  = pend;
`endif
    case (state)
      IDLE: begin
        valid_n = 1'b0;
        if (run && first_sel.found) begin
          state_n = RUN;
          addr_n  = first_sel.addr;
          valid_n = 1'b1;
          step_n  = 1'b1;
        end else if (start && !run && first_sel.found) begin
          state_n = SWEEP;
          addr_n  = first_sel.addr;
          valid_n = 1'b1;
          step_n  = 1'b1;
        end else if (start && !run) begin
          done_n = 1'b1;
        end
      end
      RUN: begin
        if (!run) begin
          state_n = IDLE;
          valid_n = 1'b0;
        end else if (blank) begin
`ifdef SCAN_BLANK_EN
          addr_n  = pend;
          valid_n = 1'b1;
          step_n  = 1'b1;
`endif
        end else if (tick) begin
          if (adv_sel.found) begin
            adv = 1'b1;
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
          end
        end
      end
      SWEEP: begin
        if (blank) begin
`ifdef SCAN_BLANK_EN
          addr_n  = pend;
          valid_n = 1'b1;
          step_n  = 1'b1;
`endif
        end else if (tick) begin
          if (adv_sel.found && in_range) begin
            adv = 1'b1;
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase

    if (adv) begin
`ifdef SCAN_BLANK_EN
      // A lone enabled line keeps its address, so there is nothing to blank.
      if (adv_sel.addr != addr) begin
        blank_n = 1'b1;
        pend_n  = adv_sel.addr;
        valid_n = 1'b0;
      end else begin
        step_n = 1'b1;
      end
`else
      addr_n = adv_sel.addr;
      step_n = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      valid <= 1'b0;
      step  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      valid <= valid_n;
      step  <= step_n;
      done  <= done_n;
    end
  end

  assign {A, B, C} = addr;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_line_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_line_scan_sequencer
// Directed, table-driven bench for line_scan_sequencer. Each table row holds
// the inputs applied before a rising edge and the outputs expected just after
// it, packed as {A,B,C,valid,step,busy,done}. The reset-abort case is a
// hand-written sequence. With SCAN_BLANK_EN defined the blanking pattern is
// exercised instead of the plain-timing tables.
// -----------------------------------------------------------------------------
module tb_line_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run, start, dir;
  logic [7:0] mask, div;
  logic       A, B, C, valid, step, busy, done;

  int checks = 0;
  int errors = 0;

  line_scan_sequencer #(.DIV_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .start (start),
    .dir   (dir),
    .mask  (mask),
    .div   (div),
    .A     (A),
    .B     (B),
    .C     (C),
    .valid (valid),
    .step  (step),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       run;
    logic       start;
    logic       dir;
    logic [7:0] mask;
    logic [7:0] div;
    logic [2:0] sel;
    logic       valid;
    logic       step;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl [100];
  int   n = 0;

  task automatic add_vec(input logic r, input logic s, input logic d,
                         input logic [7:0] m, input logic [7:0] dv,
                         input logic [2:0] sl, input logic v, input logic st,
                         input logic b, input logic dn);
    tbl[n] = '{r, s, d, m, dv, sl, v, st, b, dn};
    n++;
  endtask

  task automatic check(input string nm, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got {sel,valid,step,busy,done}=%b expected=%b", nm, got, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {A, B, C, valid, step, busy, done};
  endfunction

  initial begin
    logic [2:0] dn_seq [5];
    dn_seq = '{3'd7, 3'd5, 3'd2, 3'd0, 3'd7};

    rst_n = 1'b0;
    run   = 1'b0;
    start = 1'b0;
    dir   = 1'b0;
    mask  = 8'h00;
    div   = 8'h00;
    #12;
    check("reset", outs(), 7'b0);
    #5 rst_n = 1'b1;

`ifdef SCAN_BLANK_EN
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0)
        add_vec(1, 0, 0, 8'h03, 8'd0, 3'((k / 2) % 2), 1, 1, 1, 0);
      else
        add_vec(1, 0, 0, 8'h03, 8'd0, 3'(((k - 1) / 2) % 2), 0, 0, 1, 0);
    end
    add_vec(0, 0, 0, 8'h03, 8'd0, 3'd1, 0, 0, 0, 0);
`else
    // Continuous up scan, div=0: one line per cycle, seamless 7->0 wrap.
    for (int k = 0; k < 10; k++)
      add_vec(1, 0, 0, 8'hFF, 8'd0, 3'(k % 8), 1, 1, 1, 0);
    add_vec(0, 0, 0, 8'hFF, 8'd0, 3'd1, 0, 0, 0, 0);
    // Down scan with skips, 3-cycle dwell: 7,5,2,0,7.
    for (int k = 0; k < 13; k++)
      add_vec(1, 0, 1, 8'hA5, 8'd2, dn_seq[k / 3], 1, (k % 3 == 0), 1, 0);
    add_vec(0, 0, 1, 8'hA5, 8'd2, 3'd7, 0, 0, 0, 0);
    // Single sweep 0..3, 2-cycle dwell; stray start/run mid-sweep ignored.
    for (int k = 0; k < 8; k++)
      add_vec((k == 5), (k == 0) || (k == 4), 0, 8'h0F, 8'd1, 3'(k / 2), 1, (k % 2 == 0), 1, 0);
    add_vec(0, 0, 0, 8'h0F, 8'd1, 3'd3, 0, 0, 0, 1);
    add_vec(0, 0, 0, 8'h0F, 8'd1, 3'd3, 0, 0, 0, 0);
    // Empty mask: start gives a lone done, run stays in IDLE.
    add_vec(0, 1, 0, 8'h00, 8'd0, 3'd3, 0, 0, 0, 1);
    add_vec(0, 0, 0, 8'h00, 8'd0, 3'd3, 0, 0, 0, 0);
    add_vec(1, 0, 0, 8'h00, 8'd0, 3'd3, 0, 0, 0, 0);
    add_vec(1, 0, 0, 8'h00, 8'd0, 3'd3, 0, 0, 0, 0);
    add_vec(0, 0, 0, 8'h00, 8'd0, 3'd3, 0, 0, 0, 0);
    // Mask cleared mid-dwell: line finishes its dwell, then IDLE at the tick.
    add_vec(1, 0, 0, 8'hFF, 8'd1, 3'd0, 1, 1, 1, 0);
    add_vec(1, 0, 0, 8'h00, 8'd1, 3'd0, 1, 0, 1, 0);
    add_vec(1, 0, 0, 8'h00, 8'd1, 3'd0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 8'h00, 8'd1, 3'd0, 0, 0, 0, 0);
    // Single enabled line in RUN: select holds, step on every tick.
    for (int k = 0; k < 3; k++)
      add_vec(1, 0, 0, 8'h10, 8'd0, 3'd4, 1, 1, 1, 0);
    add_vec(0, 0, 0, 8'h10, 8'd0, 3'd4, 0, 0, 0, 0);
    // run and start together: RUN wins, no done.
    add_vec(1, 1, 0, 8'hFF, 8'd0, 3'd0, 1, 1, 1, 0);
    add_vec(1, 0, 0, 8'hFF, 8'd0, 3'd1, 1, 1, 1, 0);
    add_vec(0, 0, 0, 8'hFF, 8'd0, 3'd1, 0, 0, 0, 0);
    add_vec(0, 0, 0, 8'hFF, 8'd0, 3'd1, 0, 0, 0, 0);
`endif

    for (int i = 0; i < n; i++) begin
      run   = tbl[i].run;
      start = tbl[i].start;
      dir   = tbl[i].dir;
      mask  = tbl[i].mask;
      div   = tbl[i].div;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), outs(),
            {tbl[i].sel, tbl[i].valid, tbl[i].step, tbl[i].busy, tbl[i].done});
    end

`ifndef SCAN_BLANK_EN
    // Reset in the middle of a sweep, with the select at line 5.
    run   = 1'b0;
    dir   = 1'b0;
    mask  = 8'hFF;
    div   = 8'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("sweep_load", outs(), 7'b000_1110);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("sweep_sel%0d", k), outs(), {3'(k), 4'b1110});
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", outs(), 7'b0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("in_reset%0d", k), outs(), 7'b0);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset", outs(), 7'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_scan_sequencer.md
Name: line_scan_sequencer

Overview:
- Upstream driver for the 3-to-8 line decoder. Generates the 3-bit select {A,B,C} (A = MSB) that steps through lines 0..7 at a programmable dwell rate.
- Supports continuous scan, single sweep with start/done handshake, up/down direction and a per-line skip mask.
- Outputs connect directly to the decoder's A, B, C inputs. valid gates the decoder outputs downstream.

Parameters:
- DIV_W, 8, width of the dwell-period divisor input div.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- run  input  1  level; continuous scan while high.
- start  input  1  pulse; begin one sweep (sampled only in IDLE).
- dir  input  1  0 = ascending (0→7), 1 = descending (7→0).
- mask  input  8  bit i = 1 means line i is enabled; disabled lines are skipped.
- div  input  DIV_W  dwell = div+1 clock cycles per line.
- A  output  1  select bit 2 (MSB).
- B  output  1  select bit 1.
- C  output  1  select bit 0.
- valid  output  1  the select is live; the decoder output may be used.
- step  output  1  one-cycle pulse in the cycle the select takes a new value.
- busy  output  1  high in RUN or SWEEP.
- done  output  1  one-cycle pulse at the end of a sweep.

Behaviour:
- Reset: all registered outputs are driven immediately on rst_n low. Values: {A,B,C}=0, valid=0, step=0, busy=0, done=0, state=IDLE, prescaler=0. Reset mid-scan aborts the scan with no done pulse.
- Prescaler: counts 0..div and asserts tick when count==div, then wraps to 0. With div=0, tick fires every cycle. It resets to 0 on every line load from IDLE. A div change takes effect at the next compare.
- Line search: next(addr, dir) is the first enabled line strictly after addr in direction dir, wrapping modulo 8. first(dir) is the first enabled line starting at 0 (up) or 7 (down).
- IDLE: valid=0, busy=0, and {A,B,C} holds its last value.
  - run=1 with mask≠0 → RUN. The select loads first(dir) one cycle later, with valid=1 and step=1.
  - start=1 with run=0 and mask≠0 → SWEEP, with the same load behaviour.
  - start=1 with mask=0 → stay in IDLE; done pulses on the next cycle.
  - run and start high in the same cycle → run wins and start is dropped.
- RUN: on each tick, the select takes next(addr, dir) and step pulses.
  - The wrap from 7→0 or 0→7 is seamless.
  - run=0 → IDLE on the next cycle; valid=0 that cycle.
  - mask becoming 0 → IDLE on the next tick.
  - start is ignored.
- SWEEP: on each tick:
  - If an enabled line exists between the current line and the sweep end (7 for up, 0 for down), advance to it with step=1.
  - Otherwise go to IDLE with done=1 and valid=0 on the same cycle.
  - run and start are ignored until IDLE.
- Mask and dir are re-evaluated only at a tick. The current line dwells for its full period even if its mask bit is cleared mid-dwell.
- A single enabled line in RUN: the select stays on that line. step still pulses on every tick.
- Latency: input sampled at edge k → select, valid and step visible after edge k+1.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined: every address change inserts one blanking cycle.
  - In the tick cycle, valid drops to 0 for one clock; the new address appears with valid=1 on the following cycle, together with step.
  - The dwell of the new line starts after the blank.
  - This blanking suppresses decoder-output glitches and ghosting.
- Undefined: valid stays continuously high across line changes in RUN and SWEEP.

Decomposition:
- Package scan_pkg:
  - state enum {IDLE, RUN, SWEEP}
  - ADDR_W=3, NUM_LINES=8
  - DIR_UP=0, DIR_DOWN=1
  - function next_line(addr, dir, mask) returning {found, addr}
- Sub-module scan_tick_gen: prescaler with clk, rst_n, clr, div → tick.

Test Plan:
- Continuous up scan: reset, mask=8'hFF, div=0, dir=0, run=1 → select goes 0,1,…,7,0 on consecutive cycles; step high every cycle; busy=1.
- Skip plus down direction: mask=8'b1010_0101, div=2, dir=1, run=1 → select 7,5,2,0,7,… with each line held 3 cycles.
- Single sweep: run=0, mask=8'h0F, div=1, start pulse → select 0,1,2,3, each held 2 cycles; then done=1 for exactly one cycle with valid=0 and busy=0.
- Empty mask: mask=0, start pulse → no step, valid stays 0, done pulses once on the next cycle. With mask=0 and run=1, state remains IDLE.
- Reset and priority:
  - rst_n low mid-sweep (select at 5) → A,B,C,valid,busy drop to 0 immediately, with no done.
  - run and start asserted together → RUN is entered and no done is ever produced.
- SCAN_BLANK_EN defined: mask=8'h03, div=0, run=1 → valid pattern 1,0,1,0,… and the select changes only in cycles where valid=1.
